// File: rtl/inst_prefetch_queue_if.sv
// Handshake bundle for inst_prefetch_queue: core redirect, core instruction port and memory fetch port.
// The master modport is the prefetcher side; the slave modport is the surrounding core/memory side.
interface inst_prefetch_queue_if #(
  parameter int WORD_WIDTH_IN_BIT = 32
);
  logic                         redirect_valid;
  logic [WORD_WIDTH_IN_BIT-1:0] redirect_addr;
  logic                         inst_valid;
  logic                         inst_ready;
  logic [WORD_WIDTH_IN_BIT-1:0] inst_data;
  logic [WORD_WIDTH_IN_BIT-1:0] inst_pc;
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic [WORD_WIDTH_IN_BIT-1:0] mem_req_addr;
  logic                         mem_resp_valid;
  logic [WORD_WIDTH_IN_BIT-1:0] mem_resp_data;

  modport master (
    input  redirect_valid, redirect_addr, inst_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output inst_valid, inst_data, inst_pc,
    output mem_req_valid, mem_req_addr
  );

  modport slave (
    output redirect_valid, redirect_addr, inst_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  inst_valid, inst_data, inst_pc,
    input  mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Decoupled instruction prefetcher: sequential fetch, in-order response FIFO, redirect flush with stale drop.
// Optional macro PREFETCH_BYPASS_EN lets a response reach an empty queue's output in the same cycle.
module inst_prefetch_queue #(
  parameter int                           WORD_WIDTH_IN_BIT = 32,
  parameter int                           DEPTH             = 4,
  parameter logic [WORD_WIDTH_IN_BIT-1:0] INST_START_ADDR   = '0
) (
  input logic                   clk,
  input logic                   reset,
  inst_prefetch_queue_if.master bus
);
  localparam int              W       = WORD_WIDTH_IN_BIT;
  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]     DEPTH_X = (CW + 1)'(DEPTH);
  localparam logic [W-1:0]    PC_STEP = W'(4);

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW-1:0] trd_q, trd_d, twr_q, twr_d;
  logic [W-1:0]  fetch_pc_q, fetch_pc_d;

  logic [W-1:0]  data_mem [DEPTH];
  logic [W-1:0]  pc_mem   [DEPTH];
  logic [W-1:0]  tag_mem  [DEPTH];

  logic [CW:0]   live;
  logic          credit_ok;
  logic          issue;
  logic          resp_accept;
  logic          resp_live;
  logic          bypass_hit;
  logic          deq;
  logic          enq;

  // Credit covers queued words plus live requests, so every live response has a slot waiting.
  always_comb begin
    live        = {1'b0, outst_q} - {1'b0, disc_q};
    credit_ok   = ({1'b0, count_q} + live) < DEPTH_X;
    resp_accept = bus.mem_resp_valid && (outst_q != '0);
    resp_live   = resp_accept && (state_q == FETCH) && !bus.redirect_valid;
`ifdef PREFETCH_BYPASS_EN
    bypass_hit  = resp_live && (count_q == '0);
`else
    bypass_hit  = 1'b0;
`endif
    bus.mem_req_valid = reset && !bus.redirect_valid && credit_ok && (outst_q < DEPTH_C);
    bus.mem_req_addr  = fetch_pc_q;
    issue             = bus.mem_req_valid && bus.mem_req_ready;

    bus.inst_valid = (count_q != '0) || bypass_hit;
    bus.inst_data  = '0;
    bus.inst_pc    = '0;
    if (count_q != '0) begin
      bus.inst_data = data_mem[rd_q];
      bus.inst_pc   = pc_mem[rd_q];
    end else if (bypass_hit) begin
      bus.inst_data = bus.mem_resp_data;
      bus.inst_pc   = tag_mem[trd_q];
    end
    deq = (count_q != '0) && bus.inst_ready && !bus.redirect_valid;
    enq = resp_live && !(bypass_hit && bus.inst_ready);
  end

  // Tag FIFO tracks every outstanding request, stale or not, so it never needs flushing.
  always_comb begin
    outst_d    = outst_q + CW'(issue) - CW'(resp_accept);
    trd_d      = resp_accept ? trd_q + 1'b1 : trd_q;
    twr_d      = issue ? twr_q + 1'b1 : twr_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    fetch_pc_d = fetch_pc_q;
    disc_d     = disc_q;
    if (bus.redirect_valid) begin
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      fetch_pc_d = bus.redirect_addr;
      disc_d     = outst_d;
    end else begin
      count_d    = count_q + CW'(enq) - CW'(deq);
      rd_d       = deq ? rd_q + 1'b1 : rd_q;
      wr_d       = enq ? wr_q + 1'b1 : wr_q;
      fetch_pc_d = issue ? fetch_pc_q + PC_STEP : fetch_pc_q;
      if (resp_accept && (state_q == DISCARD)) begin
        disc_d = disc_q - 1'b1;
      end
    end
    state_d = (disc_d != '0) ? DISCARD : FETCH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      trd_q      <= '0;
      twr_q      <= '0;
      fetch_pc_q <= INST_START_ADDR;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      trd_q      <= trd_d;
      twr_q      <= twr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Storage is read only through count-gated paths, so it carries no reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[twr_q] <= fetch_pc_q;
    end
    if (enq) begin
      data_mem[wr_q] <= bus.mem_resp_data;
      pc_mem[wr_q]   <= tag_mem[trd_q];
    end
  end
endmodule
